bcd_display_scan: RTL and testbench

//  Display stage fed by the 2-digit BCD adder: captures its 3-digit sum (S2,S1,S0) on a load strobe and

---
 rtl/bcd_display_scan.sv | 143 ++++++++++++++
 tb/tb_bcd_display_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Three-digit common-anode 7-segment scanner for the BCD adder sum.
// Captures digits on load, scans D0->D1->D2 with a blanking guard, leading-zero blanking and error flag.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       err,
    output logic       frame
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2
    } slot_t;

    slot_t      slot_r, slot_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [3:0] dig0_r, dig1_r, dig2_r;
    logic [3:0] cur_dig_s;
    logic       cnt_wrap_s, blank_s, guard_s;
    logic [6:0] seg_nxt_s;
    logic [2:0] an_nxt_s, an_sel_s;
    logic       err_nxt_s, frame_nxt_s;

    // Active-low segment pattern {g,f,e,d,c,b,a}; anything above 9 renders as 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] dig);
        logic [6:0] pat;
        case (dig)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h06;
        endcase
        return pat;
    endfunction

    // Slot/counter next-state logic.
    always_comb begin
        cnt_wrap_s = (cnt_r == CNT_LAST);
        slot_nxt_s = slot_r;
        if (cnt_wrap_s) begin
            cnt_nxt_s = '0;
            case (slot_r)
                SCAN_D0: slot_nxt_s = SCAN_D1;
                SCAN_D1: slot_nxt_s = SCAN_D2;
                SCAN_D2: slot_nxt_s = SCAN_D0;
                default: slot_nxt_s = SCAN_D0;
            endcase
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Output next-values from the current slot, count and captured digits.
    always_comb begin
        cur_dig_s = 4'd0;
        blank_s   = 1'b0;
        an_sel_s  = 3'b111;
        case (slot_r)
            SCAN_D0: begin
                cur_dig_s = dig0_r;
                an_sel_s  = 3'b110;
            end
            SCAN_D1: begin
                cur_dig_s = dig1_r;
                an_sel_s  = 3'b101;
                blank_s   = (BLANK_LZ != 0) && (dig2_r == 4'd0) && (dig1_r == 4'd0);
            end
            SCAN_D2: begin
                cur_dig_s = dig2_r;
                an_sel_s  = 3'b011;
                blank_s   = (BLANK_LZ != 0) && (dig2_r == 4'd0);
            end
            default: begin
                cur_dig_s = 4'd0;
                an_sel_s  = 3'b111;
                blank_s   = 1'b1;
            end
        endcase
        guard_s = (cnt_r < GUARD_C);
        if (guard_s || blank_s) begin
            an_nxt_s  = 3'b111;
            seg_nxt_s = 7'h7F;
        end else begin
            an_nxt_s  = an_sel_s;
            seg_nxt_s = seg_decode(cur_dig_s);
        end
        err_nxt_s   = (dig0_r > 4'd9) || (dig1_r > 4'd9) || (dig2_r > 4'd9);
        frame_nxt_s = cnt_wrap_s && (slot_r == SCAN_D2);
    end

    // Scan state, digit capture and registered display outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_r  <= '0;
            slot_r <= SCAN_D0;
            dig0_r <= 4'd0;
            dig1_r <= 4'd0;
            dig2_r <= 4'd0;
            seg    <= 7'h7F;
            an     <= 3'b111;
            err    <= 1'b0;
            frame  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            slot_r <= slot_nxt_s;
            if (load) begin
                dig0_r <= d0;
                dig1_r <= d1;
                dig2_r <= d2;
            end else begin
                dig0_r <= dig0_r;
                dig1_r <= dig1_r;
                dig2_r <= dig2_r;
            end
            seg    <= seg_nxt_s;
            an     <= an_nxt_s;
            err    <= err_nxt_s;
            frame  <= frame_nxt_s;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a behavioural model queues the expected outputs each
// rising edge, and a checker pops and compares them against the DUT on the falling edge.
module tb_bcd_display_scan;
    localparam int RD = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       load   = 1'b0;
    logic [3:0] d2     = 4'd0;
    logic [3:0] d1     = 4'd0;
    logic [3:0] d0     = 4'd0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    logic       frame;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] an;
        logic       err;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   m_cnt  = 0;
    int   m_slot = 0;
    logic [3:0] m_d0 = 4'd0, m_d1 = 4'd0, m_d2 = 4'd0;
    int   cyc = 0;
    int   last_frame = -1;

    bcd_display_scan #(.REFRESH_DIV(RD), .GUARD(1), .BLANK_LZ(1)) dut (
        .clock (clk),
        .resetn(rst_n),
        .load  (load),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0),
        .seg   (seg),
        .an    (an),
        .err   (err),
        .frame (frame)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_out(input int cnt, input int slot,
                                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        logic [6:0] tbl [16];
        exp_t e;
        logic [3:0] dg;
        logic blank;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};
        dg    = (slot == 0) ? a0 : (slot == 1) ? a1 : a2;
        blank = (slot == 2 && a2 == 4'd0) || (slot == 1 && a2 == 4'd0 && a1 == 4'd0);
        e.err   = (a0 > 4'd9) || (a1 > 4'd9) || (a2 > 4'd9);
        e.frame = (cnt == RD - 1) && (slot == 2);
        if (cnt < 1 || blank) begin
            e.an  = 3'b111;
            e.seg = 7'h7F;
        end else begin
            e.an  = 3'b111;
            e.an[slot] = 1'b0;
            e.seg = tbl[dg];
        end
        return e;
    endfunction

    // Reference model: queue this cycle's expected outputs, then advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_slot <= 0;
            m_d0   <= 4'd0;
            m_d1   <= 4'd0;
            m_d2   <= 4'd0;
            q.delete();
        end else begin
            q.push_back(model_out(m_cnt, m_slot, m_d0, m_d1, m_d2));
            m_cnt  <= (m_cnt == RD - 1) ? 0 : m_cnt + 1;
            m_slot <= (m_cnt == RD - 1) ? ((m_slot + 1) % 3) : m_slot;
            if (load) begin
                m_d0 <= d0;
                m_d1 <= d1;
                m_d2 <= d2;
            end
        end
    end

    // Checker: compare DUT against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            last_frame = -1;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            assert (seg === e.seg) else begin errors++; $error("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, e.seg); end
            checks++;
            assert (an === e.an) else begin errors++; $error("FAIL an cyc=%0d got=%b exp=%b", cyc, an, e.an); end
            checks++;
            assert (err === e.err) else begin errors++; $error("FAIL err cyc=%0d got=%b exp=%b", cyc, err, e.err); end
            checks++;
            assert (frame === e.frame) else begin errors++; $error("FAIL frame cyc=%0d got=%b exp=%b", cyc, frame, e.frame); end
            if (frame === 1'b1) begin
                if (last_frame >= 0) begin
                    checks++;
                    assert (cyc - last_frame == 3 * RD) else begin
                        errors++; $error("FAIL frame_period got=%0d exp=%0d", cyc - last_frame, 3 * RD);
                    end
                end
                last_frame = cyc;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (seg === 7'h7F && an === 3'b111 && err === 1'b0 && frame === 1'b0) else begin
            errors++;
            $error("FAIL %s got seg=%h an=%b err=%b frame=%b exp seg=7f an=111 err=0 frame=0", tag, seg, an, err, frame);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] a0);
        @(negedge clk);
        d2 = a2; d1 = a1; d0 = a0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_model(input int cnt, input int slot);
        int n;
        n = 0;
        while (!(m_cnt == cnt && m_slot == slot) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (m_cnt == cnt && m_slot == slot) else begin
            errors++; $error("FAIL wait_model got cnt=%0d slot=%0d exp cnt=%0d slot=%0d", m_cnt, m_slot, cnt, slot);
        end
    endtask

    initial begin
        // 1: reset state, then blank-scan of all-zero digits
        #12;
        check_reset_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run(30);
        // 2: ordinary three-digit value
        do_load(4'd1, 4'd2, 4'd3);
        run(14);
        // 3: leading-zero blanking
        do_load(4'd0, 4'd0, 4'd7);
        run(14);
        do_load(4'd0, 4'd5, 4'd0);
        run(14);
        // 4: invalid digit shown as E and flagged, then cleared
        do_load(4'd0, 4'hC, 4'd4);
        run(14);
        do_load(4'd0, 4'd1, 4'd4);
        run(14);
        // 5: load coinciding with a slot advance
        wait_model(RD - 1, 0);
        d2 = 4'd9; d1 = 4'd8; d0 = 4'd6; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run(14);
        wait_model(RD - 1, 2);
        d2 = 4'd0; d1 = 4'd0; d0 = 4'd2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run(14);
        // 6: asynchronous reset mid SCAN_D1
        do_load(4'd4, 4'hF, 4'd5);
        wait_model(2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        run(3);
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        run(30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
